// File: rtl/logic_op_pipe.sv
// logic_op_pipe: two-stage pipelined bitwise logic unit with valid/ready handshaking and a wrapping completion counter.
// Define LOGIC_PARITY_EN to add the registered z_parity output.
module logic_op_pipe #(
    parameter int WIDTH   = 5,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   z,
`ifdef LOGIC_PARITY_EN
    output logic               z_parity,
`endif
    output logic [COUNT_W-1:0] txn_count
);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_NAND = 3'b010,
        OP_NOR  = 3'b011,
        OP_XOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_NOTA = 3'b110,
        OP_ANDN = 3'b111
    } opcode_e;

    logic               s1Valid_q, s1Valid_d;
    logic [WIDTH-1:0]   s1A_q, s1A_d;
    logic [WIDTH-1:0]   s1B_q, s1B_d;
    opcode_e            s1Op_q, s1Op_d;
    logic               s2Valid_q, s2Valid_d;
    logic [WIDTH-1:0]   s2Z_q, s2Z_d;
    logic [COUNT_W-1:0] txnCount_q, txnCount_d;
`ifdef LOGIC_PARITY_EN
    logic               s2Parity_q, s2Parity_d;
`endif

    logic             s2Load;
    logic             inFire;
    logic             outFire;
    logic [WIDTH-1:0] result;

    // S2 frees up whenever it is empty or its result is being taken this cycle.
    assign s2Load    = !s2Valid_q || out_ready;
    assign in_ready  = !s1Valid_q || s2Load;
    assign inFire    = in_valid && in_ready;
    assign outFire   = s2Valid_q && out_ready;
    assign out_valid = s2Valid_q;
    assign z         = s2Z_q;
    assign txn_count = txnCount_q;
`ifdef LOGIC_PARITY_EN
    assign z_parity  = s2Parity_q;
`endif

    always_comb begin
        result = '0;
        case (s1Op_q)
            OP_AND:  result = s1A_q & s1B_q;
            OP_OR:   result = s1A_q | s1B_q;
            OP_NAND: result = ~(s1A_q & s1B_q);
            OP_NOR:  result = ~(s1A_q | s1B_q);
            OP_XOR:  result = s1A_q ^ s1B_q;
            OP_XNOR: result = ~(s1A_q ^ s1B_q);
            OP_NOTA: result = ~s1A_q;
            OP_ANDN: result = s1A_q & ~s1B_q;
            default: result = '0;
        endcase
    end

    always_comb begin
        s1Valid_d  = s1Valid_q;
        s1A_d      = s1A_q;
        s1B_d      = s1B_q;
        s1Op_d     = s1Op_q;
        s2Valid_d  = s2Valid_q;
        s2Z_d      = s2Z_q;
        txnCount_d = txnCount_q;
`ifdef LOGIC_PARITY_EN
        s2Parity_d = s2Parity_q;
`endif

        if (inFire) begin
            s1Valid_d = 1'b1;
            s1A_d     = a;
            s1B_d     = b;
            s1Op_d    = opcode_e'(op);
        end else if (s2Load) begin
            s1Valid_d = 1'b0;
        end

        // On a bubble only the valid bit clears; the stale z is harmless while out_valid is low.
        if (s2Load) begin
            s2Valid_d = s1Valid_q;
            if (s1Valid_q) begin
                s2Z_d = result;
`ifdef LOGIC_PARITY_EN
                s2Parity_d = ^result;
`endif
            end
        end

        if (outFire) begin
            txnCount_d = txnCount_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid_q  <= 1'b0;
            s1A_q      <= '0;
            s1B_q      <= '0;
            s1Op_q     <= OP_AND;
            s2Valid_q  <= 1'b0;
            s2Z_q      <= '0;
            txnCount_q <= '0;
`ifdef LOGIC_PARITY_EN
            s2Parity_q <= 1'b0;
`endif
        end else begin
            s1Valid_q  <= s1Valid_d;
            s1A_q      <= s1A_d;
            s1B_q      <= s1B_d;
            s1Op_q     <= s1Op_d;
            s2Valid_q  <= s2Valid_d;
            s2Z_q      <= s2Z_d;
            txnCount_q <= txnCount_d;
`ifdef LOGIC_PARITY_EN
            s2Parity_q <= s2Parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_logic_op_pipe.sv
// tb_logic_op_pipe: directed stimulus against a queue-based transaction model, checked every cycle,
// with a second instance (COUNT_W=3) sharing the stimulus to exercise counter wrap.
module tb_logic_op_pipe;

    logic       clk;
    logic       rst;
    logic       inValid;
    logic       outReady;
    logic [4:0] aIn;
    logic [4:0] bIn;
    logic [2:0] opIn;

    logic       inReady,  inReadyW;
    logic       outValid, outValidW;
    logic [4:0] zOut,     zOutW;
    logic [7:0] txnCount;
    logic [2:0] txnCountW;
`ifdef LOGIC_PARITY_EN
    logic       zParity,  zParityW;
`endif

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct {
        logic [4:0] res;
        int         acc;
    } entry_t;

    entry_t expQ[$];
    entry_t newEntry;
    int     edgeCnt   = 0;
    int     doneCnt   = 0;
    bit     modelLive = 0;
    bit     headVis;
    bit     expReady;

    logic [4:0] opsLit [8] = '{5'b00100, 5'b11110, 5'b11011, 5'b00001,
                               5'b11010, 5'b00101, 5'b01001, 5'b10010};
    logic [2:0] bpOps  [4] = '{3'b001, 3'b011, 3'b101, 3'b111};
    logic [4:0] bpLit  [4] = '{5'b11110, 5'b00001, 5'b00101, 5'b10010};

    logic_op_pipe #(.WIDTH(5), .COUNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .a         (aIn),
        .b         (bIn),
        .op        (opIn),
        .out_valid (outValid),
        .out_ready (outReady),
        .z         (zOut),
`ifdef LOGIC_PARITY_EN
        .z_parity  (zParity),
`endif
        .txn_count (txnCount)
    );

    logic_op_pipe #(.WIDTH(5), .COUNT_W(3)) dutW (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReadyW),
        .a         (aIn),
        .b         (bIn),
        .op        (opIn),
        .out_valid (outValidW),
        .out_ready (outReady),
        .z         (zOutW),
`ifdef LOGIC_PARITY_EN
        .z_parity  (zParityW),
`endif
        .txn_count (txnCountW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] refOp(input logic [2:0] o, input logic [4:0] x, input logic [4:0] y);
        case (o)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return ~(x & y);
            3'd3:    return ~(x | y);
            3'd4:    return x ^ y;
            3'd5:    return ~(x ^ y);
            3'd6:    return ~x;
            default: return x & ~y;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h, at time %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] o, input logic [4:0] x,
                                 input logic [4:0] y, input logic ordy);
        @(posedge clk);
        #1;
        inValid  = v;
        opIn     = o;
        aIn      = x;
        bIn      = y;
        outReady = ordy;
    endtask

    // Model: a FIFO of at most two results; the head is visible two edges after acceptance.
    always @(posedge clk) begin
        if (rst) begin
            expQ.delete();
            doneCnt = 0;
        end else begin
            headVis  = (expQ.size() > 0) && (edgeCnt >= expQ[0].acc + 2);
            expReady = (expQ.size() < 2) || outReady;
            if (headVis && outReady) begin
                void'(expQ.pop_front());
                doneCnt++;
            end
            if (inValid && expReady) begin
                newEntry.res = refOp(opIn, aIn, bIn);
                newEntry.acc = edgeCnt;
                expQ.push_back(newEntry);
            end
        end
        edgeCnt++;
        modelLive = 1'b1;
    end

    // Compare both instances against the model away from the active edge.
    always @(negedge clk) begin
        if (modelLive) begin
            automatic bit vis = (expQ.size() > 0) && (edgeCnt >= expQ[0].acc + 2);
            automatic bit rdy = (expQ.size() < 2) || outReady;
            checkOutput("out_valid",   outValid,  vis);
            checkOutput("out_valid_w", outValidW, vis);
            checkOutput("in_ready",    inReady,   rdy);
            checkOutput("in_ready_w",  inReadyW,  rdy);
            checkOutput("txn_count",   txnCount,  32'(doneCnt % 256));
            checkOutput("txn_count_w", txnCountW, 32'(doneCnt % 8));
            if (vis) begin
                checkOutput("z",   zOut,  expQ[0].res);
                checkOutput("z_w", zOutW, expQ[0].res);
`ifdef LOGIC_PARITY_EN
                checkOutput("z_parity",   zParity,  ^expQ[0].res);
                checkOutput("z_parity_w", zParityW, ^expQ[0].res);
`endif
            end
        end
    end

    initial begin
        int j;
        int drains;

        rst      = 1'b1;
        inValid  = 1'b0;
        outReady = 1'b0;
        aIn      = '0;
        bIn      = '0;
        opIn     = '0;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_out_valid", outValid, 0);
        checkOutput("reset_z", zOut, 0);
        checkOutput("reset_txn_count", txnCount, 0);
        checkOutput("reset_in_ready", inReady, 1);

        for (int i = 0; i < 10; i++) begin
            if (i < 8) applyStimulus(1'b1, 3'(i), 5'b10110, 5'b01100, 1'b1);
            else       applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 1'b1);
            @(negedge clk);
            if (i >= 2) begin
                checkOutput("allops_valid", outValid, 1);
                checkOutput("allops_z", zOut, opsLit[i-2]);
`ifdef LOGIC_PARITY_EN
                if (i == 5) checkOutput("nor_parity", zParity, 1);
`endif
            end
        end
        applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 1'b1);
        @(negedge clk);
        checkOutput("allops_count", txnCount, 8);

        j = 0;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, bpOps[(j < 4) ? j : 3], 5'b10110, 5'b01100, 1'b0);
            @(negedge clk);
            if (inReady && j < 4) j++;
        end
        checkOutput("bp_accepted", j, 2);
        checkOutput("bp_in_ready_low", inReady, 0);
        checkOutput("bp_hold_valid", outValid, 1);
        checkOutput("bp_hold_z", zOut, 5'b11110);
        drains = 0;
        for (int c = 0; c < 12; c++) begin
            if (j < 4) applyStimulus(1'b1, bpOps[j], 5'b10110, 5'b01100, 1'b1);
            else       applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 1'b1);
            @(negedge clk);
            if (outValid) begin
                if (drains < 4) checkOutput("bp_order", zOut, bpLit[drains]);
                drains++;
            end
            if (inValid && inReady) j++;
        end
        checkOutput("bp_drained", drains, 4);

        applyStimulus(1'b1, 3'd0, 5'b11001, 5'b01011, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 3'd4, 5'b11001, 5'b01011, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 3'd1, 5'b11001, 5'b01011, 1'b0);
        @(negedge clk);
        checkOutput("sim_full_in_ready", inReady, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 3'(i + 1), 5'b00111, 5'(i), 1'b1);
            @(negedge clk);
            checkOutput("sim_in_ready", inReady, 1);
            checkOutput("sim_out_valid", outValid, 1);
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 1'b1);
            @(negedge clk);
        end
        checkOutput("sim_count", txnCount, 19);

        applyStimulus(1'b1, 3'd2, 5'b10101, 5'b11100, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 3'd3, 5'b10101, 5'b11100, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_pipe_full", inReady, 0);
        applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("rst_no_stale_valid", outValid, 0);
            checkOutput("rst_in_ready", inReady, 1);
            if (i < 3) applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 1'b1);
        end

        for (int i = 0; i < 12; i++) begin
            if (i < 9) applyStimulus(1'b1, 3'd4, 5'(i), 5'b10101, 1'b1);
            else       applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 1'b1);
            @(negedge clk);
            if (i == 9)  checkOutput("wrap_at_7", txnCountW, 7);
            if (i == 10) checkOutput("wrap_to_0", txnCountW, 0);
            if (i == 11) begin
                checkOutput("wrap_to_1", txnCountW, 1);
                checkOutput("wide_count_9", txnCount, 9);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/logic_op_pipe.md
Name: logic_op_pipe

Overview:
Parametrised, pipelined multi-function bitwise logic unit, the successor to the fixed single-gate blocks in the gate library. It accepts two WIDTH-bit operands and a 3-bit opcode per transaction under a valid/ready handshake. It returns the registered result two cycles later with full backpressure support. It also keeps a wrapping count of completed transactions for bench and debug visibility.

Parameters:
WIDTH, 5, operand/result width in bits (>=1)
COUNT_W, 8, width of completed-transaction counter (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand/opcode valid
in_ready  output  1  unit can accept a transaction this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  3  operation select
out_valid  output  1  z holds a valid result
out_ready  input  1  downstream accepts result
z  output  WIDTH  result
txn_count  output  COUNT_W  completed output handshakes, wraps modulo 2^COUNT_W

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Opcodes: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110 NOT a (b ignored), 111 ANDN (a & ~b). All ops are bitwise over WIDTH bits.
- Stage 1 (S1): registers a, b, op and s1_valid on an input handshake (in_valid & in_ready).
- Stage 2 (S2): registers the computed z and s2_valid. out_valid = s2_valid.
- Advance rules:
  - S2 loads when !s2_valid | out_ready.
  - S1 may hand off to S2 when S2 loads.
  - in_ready = !s1_valid | (S2 loads). in_ready is combinational from out_ready; no other comb path from inputs to outputs.
- Latency: a handshake in cycle N gives out_valid=1 with the result in cycle N+2 when there is no backpressure.
- Throughput: 1 transaction/cycle with out_ready held high.
- Backpressure: while out_valid & !out_ready, z and out_valid hold stable. S1 holds at most one more transaction. in_ready drops once both stages are full. No data is lost or duplicated.
- Bubbles: if S1 is empty when S2 drains, s2_valid clears. z may keep its old value but is don't-care while out_valid=0.
- Simultaneous events: an input handshake and an output handshake in the same cycle are both honoured, so a full pipe keeps streaming.
- txn_count:
  - increments by 1 on each cycle with out_valid & out_ready
  - wraps from 2^COUNT_W-1 to 0
  - no saturation
- Reset values: in_ready=1 after reset (both stages empty), out_valid=0, z=0, txn_count=0, s1_valid=0.
- Reset mid-operation: all in-flight transactions are dropped, and no out_valid pulse appears in the cycle after rst deasserts.
- Inputs a, b and op are sampled only on a handshake; they are don't-care otherwise.

Optional Feature:
LOGIC_PARITY_EN
- Defined: adds output port z_parity (1 bit) = XOR-reduction of the result. It is registered in S2 alongside z, obeys the same hold/stall rules, and resets to 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 2 cycles, then release -> out_valid=0, z=0, txn_count=0, in_ready=1.
- All ops, WIDTH=5, a=5'b10110, b=5'b01100, one per cycle, out_ready=1:
  - AND 00100, OR 11110, NAND 11011, NOR 00001, XOR 11010, XNOR 00101, NOT 01001, ANDN 10010
  - each result appears 2 cycles after its handshake
  - txn_count=8 at the end
- Backpressure: stream 4 transactions with out_ready=0 -> in_ready falls after 2 accepted and z holds the first result. Then raise out_ready -> all 4 results emerge in order, with no loss or duplication.
- Simultaneous accept/drain: with both stages full, assert in_valid=1 and out_ready=1 for 5 cycles -> 5 accepts and 5 drains, and in_ready stays 1.
- Counter wrap: COUNT_W=3, complete 9 transactions -> txn_count sequence reaches 7, then reads 0, then 1.
- Mid-operation reset and parity:
  - assert rst with both stages full -> out_valid=0 on the next cycle, and no stale result appears afterwards
  - with LOGIC_PARITY_EN, NOR of 10110/01100 -> z_parity=1
